// File: rtl/axi_line_fill_master.sv
// AXI4 read-only line-fill initiator: one cache-miss request becomes one aligned INCR burst.
// Optional critical-word forwarding and RID checking are enabled by LINE_FILL_CRIT_WORD_FWD_EN.
module axi_line_fill_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int AXI_ID     = 0,
  parameter int ID_WIDTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  output logic                             line_valid,
  output logic [ADDR_WIDTH-1:0]            line_addr,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] line_data,
  output logic                             line_err,
`ifdef LINE_FILL_CRIT_WORD_FWD_EN
  output logic                             crit_valid,
  output logic [DATA_WIDTH-1:0]            crit_data,
`endif
  output logic [ID_WIDTH-1:0]              m_axi_arid,
  output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
  output logic [7:0]                       m_axi_arlen,
  output logic [2:0]                       m_axi_arsize,
  output logic [1:0]                       m_axi_arburst,
  output logic                             m_axi_arvalid,
  input  logic                             m_axi_arready,
  input  logic [ID_WIDTH-1:0]              m_axi_rid,
  input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
  input  logic [1:0]                       m_axi_rresp,
  input  logic                             m_axi_rlast,
  input  logic                             m_axi_rvalid,
  output logic                             m_axi_rready
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int WORD_LSB = $clog2(BYTES);
  localparam int OFF      = $clog2(LINE_WORDS * BYTES);
  localparam int CW       = $clog2(LINE_WORDS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(LINE_WORDS);
  localparam logic [CW-1:0] CNT_LAST = CW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_DONE} state_t;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           cnt_reg;
  logic                    err_reg;
  logic [ADDR_WIDTH-1:0]   araddr_reg;
  logic [ADDR_WIDTH-1:0]   line_addr_reg;
  logic [ADDR_WIDTH-1:0]   aligned_addr;
  logic                    accept;
  logic                    beat_fire;
  logic                    beat_err;

  assign aligned_addr = {req_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
  assign accept       = (state_reg == ST_IDLE) && req_valid;
  assign beat_fire    = (state_reg == ST_DATA) && m_axi_rvalid;

  always_comb begin
    beat_err = m_axi_rresp[1] || (m_axi_rlast && (cnt_reg != CNT_LAST)) || (cnt_reg == CNT_FULL);
`ifdef LINE_FILL_CRIT_WORD_FWD_EN
    if (m_axi_rid != ID_WIDTH'(AXI_ID))
      beat_err = 1'b1;
`endif
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req_valid)                     state_next = ST_ADDR;
      ST_ADDR: if (m_axi_arready)                 state_next = ST_DATA;
      ST_DATA: if (m_axi_rvalid && m_axi_rlast)   state_next = ST_DONE;
      ST_DONE:                                    state_next = ST_IDLE;
      default:                                    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      err_reg       <= 1'b0;
      araddr_reg    <= '0;
      line_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        araddr_reg    <= aligned_addr;
        line_addr_reg <= aligned_addr;
        cnt_reg       <= '0;
        err_reg       <= 1'b0;
      end else if (beat_fire) begin
        // Counter parks at LINE_WORDS so overrun beats are flagged and dropped.
        if (cnt_reg != CNT_FULL)
          cnt_reg <= cnt_reg + CW'(1);
        if (beat_err)
          err_reg <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
    logic [DATA_WIDTH-1:0] word_reg;
    always_ff @(posedge clk) begin
      if (!rst_n)
        word_reg <= '0;
      else if (beat_fire && (cnt_reg == CW'(gi)))
        word_reg <= m_axi_rdata;
    end
    assign line_data[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;
  end

`ifdef LINE_FILL_CRIT_WORD_FWD_EN
  logic [OFF-WORD_LSB-1:0] crit_idx_reg;
  logic                    crit_valid_reg;
  logic [DATA_WIDTH-1:0]   crit_data_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crit_idx_reg   <= '0;
      crit_valid_reg <= 1'b0;
      crit_data_reg  <= '0;
    end else begin
      if (accept)
        crit_idx_reg <= req_addr[OFF-1:WORD_LSB];
      crit_valid_reg <= beat_fire && (cnt_reg == CW'(crit_idx_reg));
      if (beat_fire && (cnt_reg == CW'(crit_idx_reg)))
        crit_data_reg <= m_axi_rdata;
    end
  end

  assign crit_valid = crit_valid_reg;
  assign crit_data  = crit_data_reg;

  logic unused_bits;
  assign unused_bits = m_axi_rresp[0];
`else
  logic unused_bits;
  assign unused_bits = ^{m_axi_rresp[0], m_axi_rid};
`endif

  assign req_ready     = (state_reg == ST_IDLE);
  assign m_axi_arvalid = (state_reg == ST_ADDR);
  assign m_axi_rready  = (state_reg == ST_DATA);
  assign line_valid    = (state_reg == ST_DONE);
  assign line_err      = (state_reg == ST_DONE) && err_reg;
  assign line_addr     = line_addr_reg;
  assign m_axi_araddr  = araddr_reg;
  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign m_axi_arlen   = 8'(LINE_WORDS - 1);
  assign m_axi_arsize  = 3'(WORD_LSB);
  assign m_axi_arburst = 2'b01;

endmodule

// File: tb/tb_axi_line_fill_master.sv
// Randomized bench for axi_line_fill_master: a behavioural AXI read slave plus a line model.
// Define LINE_FILL_CRIT_WORD_FWD_EN to also exercise critical-word forwarding and RID checks.
module tb_axi_line_fill_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int IW = 4;
  localparam int AXI_ID = 0;
  localparam int LINE_BYTES = LW * DW / 8;

  logic            clk;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic            line_valid;
  logic [AW-1:0]   line_addr;
  logic [LW*DW-1:0] line_data;
  logic            line_err;
`ifdef LINE_FILL_CRIT_WORD_FWD_EN
  logic            crit_valid;
  logic [DW-1:0]   crit_data;
`endif
  logic [IW-1:0]   m_axi_arid;
  logic [AW-1:0]   m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic [2:0]      m_axi_arsize;
  logic [1:0]      m_axi_arburst;
  logic            m_axi_arvalid;
  logic            m_axi_arready;
  logic [IW-1:0]   m_axi_rid;
  logic [DW-1:0]   m_axi_rdata;
  logic [1:0]      m_axi_rresp;
  logic            m_axi_rlast;
  logic            m_axi_rvalid;
  logic            m_axi_rready;

  axi_line_fill_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW), .AXI_ID(AXI_ID), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .line_valid(line_valid), .line_addr(line_addr), .line_data(line_data), .line_err(line_err),
`ifdef LINE_FILL_CRIT_WORD_FWD_EN
    .crit_valid(crit_valid), .crit_data(crit_data),
`endif
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int txn_cnt   = 0;

  logic [31:0]   mem [256];
  logic [DW-1:0] model_line [LW];

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total_cnt++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      pass_cnt++;
  endtask

  // kind: 0 clean, 1 SLVERR/DECERR on err_beat, 2 early rlast at err_beat,
  //       3 one beat too many, 4 wrong RID on err_beat, 5 EXOKAY on err_beat
  task automatic run_txn(input logic [31:0] addr, input int ar_delay, input int gap_min,
                         input int gap_max, input int kind, input int err_beat,
                         input bit hold, input int abort_beats);
    logic [31:0]      base;
    logic [LW*DW-1:0] exp_line;
    int               cidx;
    int               nbeats;
    int               t;
    bit               exp_err;
    base    = addr - (addr % LINE_BYTES);
    cidx    = (addr / (DW / 8)) % LW;
    nbeats  = (kind == 2) ? err_beat + 1 : (kind == 3) ? LW + 1 : LW;
    exp_err = (kind == 1) || (kind == 2) || (kind == 3);
`ifdef LINE_FILL_CRIT_WORD_FWD_EN
    exp_err = exp_err || (kind == 4);
`endif
    req_addr  = addr;
    req_valid = 1'b1;
    t = 0;
    while (req_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      check_val("req_ready_timeout", 0, 1);
      return;
    end
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    check_val("req_ready_busy", req_ready, 0);
    check_val("arvalid_rise", m_axi_arvalid, 1);
    for (int d = 0; d < ar_delay; d++) begin
      check_val("arvalid_hold", m_axi_arvalid, 1);
      @(negedge clk);
    end
    check_val("araddr", m_axi_araddr, base);
    check_val("arlen", m_axi_arlen, LW - 1);
    check_val("arsize", m_axi_arsize, (DW == 64) ? 3 : 2);
    check_val("arburst", m_axi_arburst, 1);
    check_val("arid", m_axi_arid, AXI_ID);
    m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
    check_val("arvalid_fall", m_axi_arvalid, 0);
    for (int b = 0; b < nbeats; b++) begin
      int gap;
      gap = $urandom_range(gap_min, gap_max);
      for (int g = 0; g < gap; g++) begin
        m_axi_rvalid = 1'b0;
        @(negedge clk);
      end
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = (b < LW) ? mem[((base >> 2) + b) % 256] : $urandom;
      m_axi_rresp  = 2'b00;
      m_axi_rid    = IW'(AXI_ID);
      if (b == err_beat && kind == 1) m_axi_rresp = 2'($urandom_range(2, 3));
      if (b == err_beat && kind == 5) m_axi_rresp = 2'b01;
      if (b == err_beat && kind == 4) m_axi_rid = IW'(AXI_ID + $urandom_range(1, 15));
      m_axi_rlast = (b == nbeats - 1);
      check_val("rready", m_axi_rready, 1);
      @(negedge clk);
      if (b < LW) model_line[b] = m_axi_rdata;
`ifdef LINE_FILL_CRIT_WORD_FWD_EN
      check_val("crit_valid", crit_valid, (b == cidx));
      if (b == cidx) check_val("crit_data", crit_data, m_axi_rdata);
`endif
      if (abort_beats != 0 && b + 1 == abort_beats) begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_val("rst_arvalid", m_axi_arvalid, 0);
        check_val("rst_rready", m_axi_rready, 0);
        check_val("rst_req_ready", req_ready, 1);
        check_val("rst_line_valid", line_valid, 0);
        check_val("rst_line_data", line_data, 0);
        check_val("rst_line_addr", line_addr, 0);
        for (int i = 0; i < LW; i++) model_line[i] = '0;
        rst_n = 1'b1;
        @(negedge clk);
        $display("txn %0d addr=%h aborted by reset after %0d beats", txn_cnt, addr, abort_beats);
        txn_cnt++;
        return;
      end
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    for (int i = 0; i < LW; i++) exp_line[i*DW +: DW] = model_line[i];
    check_val("line_valid", line_valid, 1);
    check_val("line_err", line_err, exp_err);
    check_val("line_addr", line_addr, base);
    check_val("line_data", line_data, exp_line);
    check_val("req_ready_done", req_ready, 0);
    @(negedge clk);
    check_val("line_valid_once", line_valid, 0);
    check_val("req_ready_idle", req_ready, 1);
    $display("txn %0d addr=%h kind=%0d beats=%0d line_err=%0b", txn_cnt, addr, kind, nbeats, exp_err);
    txn_cnt++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rid = IW'(AXI_ID);
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[128] = 32'hfe010113; mem[129] = 32'h00112e23;
    mem[130] = 32'h00812c23; mem[131] = 32'h02010413;
    for (int i = 0; i < LW; i++) model_line[i] = '0;
    repeat (3) @(negedge clk);
    check_val("reset_req_ready", req_ready, 1);
    check_val("reset_arvalid", m_axi_arvalid, 0);
    check_val("reset_rready", m_axi_rready, 0);
    check_val("reset_line_valid", line_valid, 0);
    check_val("reset_line_err", line_err, 0);
    check_val("reset_line_data", line_data, 0);
    check_val("reset_line_addr", line_addr, 0);
    check_val("reset_araddr", m_axi_araddr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(32'h208, 0, 0, 0, 0, 0, 0, 0);
    check_val("basic_line", line_data, 128'h02010413_00812c23_00112e23_fe010113);
    run_txn(32'h3A4, 5, 1, 1, 0, 0, 0, 0);
    run_txn(32'h134, 0, 0, 0, 1, 2, 0, 0);
    run_txn(32'h0E8, 0, 0, 0, 2, 1, 0, 0);
    run_txn(32'h080, 0, 0, 0, 0, 0, 1, 0);
    run_txn(32'h084, 0, 0, 0, 0, 0, 0, 0);
    run_txn(32'h204, 0, 0, 0, 0, 0, 0, 2);
    run_txn(32'h200, 0, 0, 0, 0, 0, 0, 0);
    run_txn(32'h20C, 0, 0, 0, 0, 0, 0, 0);
    run_txn(32'h050, 1, 0, 1, 3, 0, 0, 0);
    run_txn(32'h2F8, 0, 0, 0, 4, 3, 0, 0);
    run_txn(32'h11C, 2, 0, 2, 5, 0, 0, 0);
    for (int n = 0; n < 30; n++) begin
      int kind;
      int eb;
      kind = $urandom_range(0, 5);
      eb   = (kind == 2) ? $urandom_range(0, LW - 2) : $urandom_range(0, LW - 1);
      run_txn($urandom_range(0, 1023), $urandom_range(0, 3), 0, $urandom_range(0, 2), kind, eb, 0, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
